spi_master_multi: RTL
=====================

# spi_master_multi

Parametrised SPI master serving up to NUM_SS slaves on a shared SCLK/MOSI/MISO bus, replacing the fixed 3-bit, single-mode, free-running-clock master in the board top-level. It has a programmable SCLK divider, runtime-selectable SPI mode (CPOL/CPHA), full-duplex MISO capture, and a busy/valid handshake. It sits between switch/control logic and the slave endpoints and is clocked directly from the board clock, so no derived-clock domain is needed.

## Interface
- DATA_W, 8: bits per transfer, 2..32, MSB first.
- NUM_SS, 2: number of active-low slave selects, 1..8.
- CLK_DIV, 4: clk cycles per SCLK half-period, ≥1.
- SEL_W, $clog2(NUM_SS) (min 1): width of slave_sel.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- send  in  1  transfer request, level-sampled while idle.
- slave_sel  in  SEL_W  target slave index, latched on accept.
- cpol  in  1  SCLK idle level, latched on accept.
- cpha  in  1  clock phase, latched on accept.
- tx_data  in  DATA_W  word to transmit, latched on accept.
- miso  in  1  serial data from slaves.
- sclk  out  1  serial clock.
- mosi  out  1  serial data to slaves.
- ss_n  out  NUM_SS  active-low slave selects, one-hot-low when active.
- busy  out  1  transfer in progress.
- rx_data  out  DATA_W  last received word, held until next completion.
- rx_valid  out  1  one-cycle pulse on completion.

## Operation
- States: IDLE, LEAD, XFER, TRAIL.
- IDLE: send=1 sampled high → latch tx_data/slave_sel/cpol/cpha, go LEAD. sclk=latched cpol.
- LEAD: busy=1, ss_n[slave_sel]=0; CLK_DIV cycles, then XFER.
- XFER: 2·DATA_W SCLK edges, one every CLK_DIV cycles; after last edge go TRAIL.
- TRAIL: sclk at idle level; after CLK_DIV cycles ss_n all 1, busy=0, rx_valid=1, rx_data updated, go IDLE.
- cpha=0: mosi = MSB from LEAD entry; odd edges sample miso, even edges shift next bit out (final even edge does not shift). mosi holds LSB through TRAIL.
- cpha=1: mosi=0 in LEAD; odd edges shift out next bit (first edge drives MSB), even edges sample miso.
- Received bits shift in MSB first; rx_data written only at completion.
- slave_sel ≥ NUM_SS: transfer runs normally with all ss_n high; rx_data/rx_valid still produced.
- Inputs other than miso are ignored while busy.
- Reset values: sclk=0, mosi=0, ss_n=all 1, busy=0, rx_valid=0, rx_data=0, state IDLE, latched cpol=0.
- reset low mid-transfer: all outputs take reset values on that edge; no rx_valid; partial data discarded.

## Timing
- Cycle T send sampled high in IDLE → busy=1 and ss_n asserted at T+1.
- First SCLK edge at T+1+CLK_DIV; edge k at T+1+k·CLK_DIV, k=1..2·DATA_W.
- ss_n deassert, busy fall, rx_valid pulse all at T+1+(2·DATA_W+1)·CLK_DIV.
- Default parameters: 68 cycles from ss_n assert to completion.
- send held high: next accept the cycle after busy falls → exactly one cycle with ss_n all high between transfers.
- miso sampled on the clk edge that produces the sampling SCLK edge (no extra synchroniser).

## Configuration
- SPI_LOOPBACK_EN defined: miso input ignored; receive shifter samples internal mosi, so rx_data equals tx_data for every mode. Pins unchanged.
- Undefined: receive shifter samples miso port.

## Test plan
- Mode 0, tx_data=0xA5, slave_sel=1, miso tied to a slave model returning 0x3C → ss_n=2'b01 for 68 cycles, MOSI bits 1,0,1,0,0,1,0,1 on rising edges, rx_data=0x3C, one rx_valid pulse.
- Modes 1/2/3 with tx_data=0x81 → sclk idle level equals cpol, sampling on correct edge, rx_data matches slave model in each.
- send held high for three transfers (0x11,0x22,0x33) → exactly one idle cycle with ss_n all 1 between transfers, three rx_valid pulses.
- reset low at cycle 30 of a transfer → next cycle ss_n=all 1, sclk=0, busy=0, no rx_valid, rx_data unchanged 0.
- slave_sel=3 with NUM_SS=2 → all ss_n stay high, 68-cycle transfer completes with rx_valid.
- SPI_LOOPBACK_EN defined, DATA_W=16, CLK_DIV=1, tx_data=0xBEEF → rx_data=0xBEEF after 34 cycles.

Source files
------------

// File: rtl/spi_master_multi.sv
// SPI master for up to NUM_SS slaves: programmable SCLK divider, per-transfer CPOL/CPHA, full-duplex capture.
// Define SPI_LOOPBACK_EN to feed the receive shifter from internal MOSI instead of the MISO pin.
module spi_master_multi #(
    parameter int DATA_W  = 8,
    parameter int NUM_SS  = 2,
    parameter int CLK_DIV = 4,
    parameter int SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              send_i,
    input  logic [SEL_W-1:0]  slave_sel_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              miso_i,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic [NUM_SS-1:0] ss_n_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o
);

    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [EDGE_W-1:0]   edge_q;
    logic                cpol_q;
    logic                cpha_q;
    logic                sclk_q;
    logic                mosi_q;
    logic [NUM_SS-1:0]   ss_n_q;
    logic                busy_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic [DATA_W-1:0]   tx_q;
    logic [DATA_W-1:0]   rx_q;

    logic                tick_d;
    logic                accept_d;
    logic                edge_en_d;
    logic [EDGE_W-1:0]   edge_k_d;
    logic                shift_en_d;
    logic                sample_en_d;
    logic                sample_bit_d;
    logic [NUM_SS-1:0]   ss_sel_d;

    // Out-of-range selects decode to all-high, so the transfer still runs with no slave enabled.
    always_comb begin
        ss_sel_d = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(slave_sel_i) == i) ss_sel_d[i] = 1'b0;
        end
    end

    always_comb begin
        tick_d      = (cnt_q == CNT_LAST);
        accept_d    = (state_q == S_IDLE) && send_i;
        edge_en_d   = tick_d && ((state_q == S_LEAD) || (state_q == S_XFER));
        edge_k_d    = edge_q + EDGE_W'(1);
        // The final even edge of a CPHA=0 transfer must not shift, so MOSI holds the LSB through TRAIL.
        shift_en_d  = edge_en_d && (cpha_q ? edge_k_d[0] : (!edge_k_d[0] && (edge_k_d != EDGE_LAST)));
        sample_en_d = edge_en_d && (cpha_q ? !edge_k_d[0] : edge_k_d[0]);
`ifdef SPI_LOOPBACK_EN
        sample_bit_d = mosi_q;
`else
        sample_bit_d = miso_i;
`endif
    end

    // Shift registers carry only data; every transfer fully refills them, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (accept_d) begin
            tx_q <= tx_data_i;
        end else if (shift_en_d) begin
            tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        end
        if (sample_en_d) begin
            rx_q <= {rx_q[DATA_W-2:0], sample_bit_d};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (send_i) begin
                        cpol_q  <= cpol_i;
                        cpha_q  <= cpha_i;
                        sclk_q  <= cpol_i;
                        mosi_q  <= cpha_i ? 1'b0 : tx_data_i[DATA_W-1];
                        ss_n_q  <= ss_sel_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        state_q <= S_LEAD;
                    end
                end
                S_LEAD, S_XFER: begin
                    if (tick_d) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_k_d;
                        if (shift_en_d) begin
                            mosi_q <= cpha_q ? tx_q[DATA_W-1] : tx_q[DATA_W-2];
                        end
                        state_q <= (edge_k_d == EDGE_LAST) ? S_TRAIL : S_XFER;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_TRAIL: begin
                    if (tick_d) begin
                        cnt_q      <= '0;
                        ss_n_q     <= '1;
                        busy_q     <= 1'b0;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_q;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sclk_o     = sclk_q;
    assign mosi_o     = mosi_q;
    assign ss_n_o     = ss_n_q;
    assign busy_o     = busy_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule
